// File: rtl/jtag_dtm_tap.sv
// jtag_dtm_tap: RISC-V JTAG Debug Transport Module with TCK oversampled in the
// clk domain. It runs the TAP controller, the 5-bit IR and the IDCODE/DTMCS/DMI/
// BYPASS data registers, and turns DMI scans into requests to the debug module.
// Optional feature: define JTAG_DTM_IDCODE_EN to include the IDCODE register.
// Without it, IR 5'h01 decodes as BYPASS and IR resets to 5'h1f.
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1e200a6d,
    parameter int unsigned DMI_ABITS    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  jtag_TCK,
    input  logic                  jtag_TMS,
    input  logic                  jtag_TDI,
    output logic                  jtag_TDO,
    output logic                  dtm_req_valid,
    input  logic                  dtm_req_ready,
    output logic [DMI_ABITS+33:0] dtm_req_data,
    input  logic                  dm_resp_valid,
    input  logic [33:0]           dm_resp_data
);
    localparam int unsigned DR_W      = DMI_ABITS + 34;
    localparam logic [4:0]  IR_IDCODE = 5'h01;
    localparam logic [4:0]  IR_DTMCS  = 5'h10;
    localparam logic [4:0]  IR_DMI    = 5'h11;
`ifdef JTAG_DTM_IDCODE_EN
    localparam logic        HAS_IDCODE = 1'b1;
    localparam logic [4:0]  IR_RESET   = IR_IDCODE;
`else
    localparam logic        HAS_IDCODE = 1'b0;
    localparam logic [4:0]  IR_RESET   = 5'h1f;
`endif

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    tap_state_e            state_q, state_d;
    logic [1:0]            tck_sync_q, tck_sync_d, tms_sync_q, tms_sync_d, tdi_sync_q, tdi_sync_d;
    logic                  tck_prev_q, tck_prev_d, tap_adv_q, tap_adv_d;
    logic [4:0]            ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DR_W-1:0]       dr_sr_q, dr_sr_d, req_data_q, req_data_d;
    logic                  tdo_q, tdo_d, req_valid_q, req_valid_d;
    logic                  busy_q, busy_d, sticky_q, sticky_d;
    logic [33:0]           resp_q, resp_d;
    logic [DMI_ABITS-1:0]  last_addr_q, last_addr_d;
    logic                  tck_rise, tck_fall, tms, tdi, upd_dr, upd_ir;
    logic                  sel_idcode, sel_dtmcs, sel_dmi;
    logic [1:0]            dmistat, dmi_status;

    assign jtag_TDO      = tdo_q;
    assign dtm_req_valid = req_valid_q;
    assign dtm_req_data  = req_data_q;

    // Register every piece of state; reset aborts any scan or pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            tck_prev_q  <= 1'b0;
            tap_adv_q   <= 1'b0;
            state_q     <= TLR;
            ir_q        <= IR_RESET;
            ir_sr_q     <= '0;
            dr_sr_q     <= '0;
            tdo_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_data_q  <= '0;
            busy_q      <= 1'b0;
            sticky_q    <= 1'b0;
            resp_q      <= '0;
            last_addr_q <= '0;
        end else begin
            tck_sync_q  <= tck_sync_d;
            tms_sync_q  <= tms_sync_d;
            tdi_sync_q  <= tdi_sync_d;
            tck_prev_q  <= tck_prev_d;
            tap_adv_q   <= tap_adv_d;
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            dr_sr_q     <= dr_sr_d;
            tdo_q       <= tdo_d;
            req_valid_q <= req_valid_d;
            req_data_q  <= req_data_d;
            busy_q      <= busy_d;
            sticky_q    <= sticky_d;
            resp_q      <= resp_d;
            last_addr_q <= last_addr_d;
        end
    end

    // Pin synchronizers, TCK edge detection and update-state entry strobes.
    always_comb begin
        tck_sync_d = {tck_sync_q[0], jtag_TCK};
        tms_sync_d = {tms_sync_q[0], jtag_TMS};
        tdi_sync_d = {tdi_sync_q[0], jtag_TDI};
        tck_prev_d = tck_sync_q[1];
        tck_rise   = tck_sync_q[1] & ~tck_prev_q;
        tck_fall   = ~tck_sync_q[1] & tck_prev_q;
        tms        = tms_sync_q[1];
        tdi        = tdi_sync_q[1];
        tap_adv_d  = tck_rise;
        upd_dr     = tap_adv_q && (state_q == UPD_DR);
        upd_ir     = tap_adv_q && (state_q == UPD_IR);
    end

    // TAP controller next state, advancing on each synced TCK rise.
    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TLR:     state_d = tms ? TLR    : RTI;
                RTI:     state_d = tms ? SEL_DR : RTI;
                SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms ? UPD_DR : PA_DR;
                PA_DR:   state_d = tms ? EX2_DR : PA_DR;
                EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms ? SEL_DR : RTI;
                SEL_IR:  state_d = tms ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms ? UPD_IR : PA_IR;
                PA_IR:   state_d = tms ? EX2_IR : PA_IR;
                EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    // Instruction decode and the status fields reported by DTMCS and DMI captures.
    always_comb begin
        sel_idcode = HAS_IDCODE && (ir_q == IR_IDCODE);
        sel_dtmcs  = (ir_q == IR_DTMCS);
        sel_dmi    = (ir_q == IR_DMI);
        dmistat    = sticky_q ? 2'b11 : 2'b00;
        dmi_status = (sticky_q || busy_q) ? 2'b11 : resp_q[1:0];
    end

    // IR and DR shift registers and TDO; TDI always enters at the selected DR's MSB.
    always_comb begin
        ir_d    = ir_q;
        ir_sr_d = ir_sr_q;
        dr_sr_d = dr_sr_q;
        tdo_d   = tdo_q;
        if (state_q == TLR) ir_d = IR_RESET;
        if (upd_ir) ir_d = ir_sr_q;
        if (tck_rise && state_q == CAP_IR) ir_sr_d = 5'b00001;
        if (tck_rise && state_q == SH_IR) ir_sr_d = {tdi, ir_sr_q[4:1]};
        if (tck_rise && state_q == CAP_DR) begin
            if (sel_idcode)
                dr_sr_d = {{(DR_W-32){1'b0}}, IDCODE_VALUE};
            else if (sel_dtmcs)
                dr_sr_d = {{(DR_W-32){1'b0}}, 14'b0, 2'b0, 1'b0, 3'd0, dmistat, 6'(DMI_ABITS), 4'd1};
            else if (sel_dmi)
                dr_sr_d = {last_addr_q, resp_q[33:2], dmi_status};
            else
                dr_sr_d = '0;
        end
        if (tck_rise && state_q == SH_DR) begin
            if (sel_dmi)
                dr_sr_d = {tdi, dr_sr_q[DR_W-1:1]};
            else if (sel_idcode || sel_dtmcs)
                dr_sr_d = {{(DR_W-32){1'b0}}, tdi, dr_sr_q[31:1]};
            else
                dr_sr_d = {{(DR_W-1){1'b0}}, tdi};
        end
        if (tck_fall) begin
            if (state_q == SH_DR)      tdo_d = dr_sr_q[0];
            else if (state_q == SH_IR) tdo_d = ir_sr_q[0];
            else                       tdo_d = 1'b0;
        end
    end

    // DMI request/response tracking; a same-cycle response clears busy before a new update is judged.
    always_comb begin
        req_valid_d = req_valid_q;
        req_data_d  = req_data_q;
        busy_d      = busy_q;
        sticky_d    = sticky_q;
        resp_d      = resp_q;
        last_addr_d = last_addr_q;
        if (req_valid_q && dtm_req_ready) req_valid_d = 1'b0;
        if (dm_resp_valid && busy_q) begin
            resp_d = dm_resp_data;
            busy_d = 1'b0;
        end
        if (upd_dr && sel_dtmcs) begin
            if (dr_sr_q[17]) begin
                sticky_d    = 1'b0;
                busy_d      = 1'b0;
                req_valid_d = 1'b0;
            end else if (dr_sr_q[16]) begin
                sticky_d = 1'b0;
            end
        end
        if (upd_dr && sel_dmi && dr_sr_q[1:0] != 2'b00) begin
            if (busy_d) begin
                sticky_d = 1'b1;
            end else if (!sticky_q) begin
                req_data_d  = dr_sr_q;
                req_valid_d = 1'b1;
                busy_d      = 1'b1;
                last_addr_d = dr_sr_q[DR_W-1 -: DMI_ABITS];
            end
        end
    end
endmodule

// File: tb/tb_jtag_dtm_tap.sv
// tb_jtag_dtm_tap: directed bench for jtag_dtm_tap. Drives TCK slowly (5 clk per
// phase) and checks TDO scan-out, DMI requests and reset behaviour against
// hand-computed values. Honours JTAG_DTM_IDCODE_EN for the reset-scan result.
module tb_jtag_dtm_tap;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jtag_TCK = 1'b0, jtag_TMS = 1'b1, jtag_TDI = 1'b0;
    logic        jtag_TDO;
    logic        dtm_req_valid;
    logic        dtm_req_ready = 1'b0;
    logic [39:0] dtm_req_data;
    logic        dm_resp_valid = 1'b0;
    logic [33:0] dm_resp_data = '0;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    int hs_cnt = 0;
    logic vprev = 1'b0;

    jtag_dtm_tap dut (
        .clk(clk), .rst_n(rst_n),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO),
        .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready), .dtm_req_data(dtm_req_data),
        .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data)
    );

    always #5 clk = ~clk;

    // Count request-valid rising edges and handshakes.
    always @(posedge clk) begin
        vprev <= dtm_req_valid;
        if (dtm_req_valid === 1'b1 && vprev !== 1'b1) rise_cnt <= rise_cnt + 1;
        if (dtm_req_valid === 1'b1 && dtm_req_ready === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        repeat (5) @(negedge clk);
        tdo = jtag_TDO;
        jtag_TCK = 1'b1;
        repeat (5) @(negedge clk);
        jtag_TCK = 1'b0;
    endtask

    // From RTI: scan n DR bits LSB-first, finish through UPD_DR back to RTI.
    task automatic shift_dr(input int n, input logic [39:0] tdi_v, output logic [39:0] out);
        logic b;
        out = '0;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, tdi_v[i], b);
            out[i] = b;
        end
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
    endtask

    task automatic shift_ir(input logic [4:0] v, output logic [4:0] out);
        logic b;
        out = '0;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, v[i], b);
            out[i] = b;
        end
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
    endtask

    task automatic tap_reset_to_rti();
        logic b;
        for (int i = 0; i < 8; i++) tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (dtm_req_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, {39'b0, dtm_req_valid}, 40'h1);
    endtask

    task automatic handshake(input int delay);
        repeat (delay) @(negedge clk);
        dtm_req_ready = 1'b1;
        @(negedge clk);
        dtm_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [33:0] v);
        dm_resp_data  = v;
        dm_resp_valid = 1'b1;
        @(negedge clk);
        dm_resp_valid = 1'b0;
        dm_resp_data  = '0;
    endtask

    initial begin
        logic [39:0] out;
        logic [4:0]  iro;
        logic [31:0] pat;
        logic [39:0] exp_reset_scan;
        logic        b;
        pat = 32'hA5C3_0F96;
`ifdef JTAG_DTM_IDCODE_EN
        exp_reset_scan = {8'h00, 32'h1e200a6d};
`else
        exp_reset_scan = {8'h00, pat[30:0], 1'b0};
`endif

        // Power-on reset values
        repeat (3) @(negedge clk);
        check("rst_tdo", {39'b0, jtag_TDO}, 40'h0);
        check("rst_valid", {39'b0, dtm_req_valid}, 40'h0);
        check("rst_data", dtm_req_data, 40'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // TAP reset then 32-bit DR scan (IDCODE or BYPASS)
        tap_reset_to_rti();
        shift_dr(32, {8'h00, pat}, out);
        check("reset_dr_scan", out, exp_reset_scan);

        // IR scan to DMI
        shift_ir(5'b10001, iro);
        check("ir_capture", {35'b0, iro}, 40'h1);
        check("ir_no_req", {8'b0, 24'(rise_cnt)} & 40'hff_ffff_ffff, 40'h0);

        // DMI write
        shift_dr(40, 40'h40_0000_0002, out);
        check("wr_capture", out, 40'h0);
        wait_valid("wr_valid");
        check("wr_data", dtm_req_data, 40'h40_0000_0002);
        handshake(2);
        check("wr_valid_drop", {39'b0, dtm_req_valid}, 40'h0);
        check("wr_hs_cnt", 40'(hs_cnt), 40'd1);
        respond(34'h0);

        // DMI read of address 0x11
        shift_dr(40, 40'h44_0000_0001, out);
        check("rd_capture", out, 40'h40_0000_0000);
        wait_valid("rd_valid");
        check("rd_data", dtm_req_data, 40'h44_0000_0001);
        handshake(1);
        respond({32'h0000_0c82, 2'b00});

        // Nop scan returns the read data, issues nothing
        shift_dr(40, 40'h0, out);
        check("nop_capture", out, 40'h44_0000_3208);
        repeat (10) @(negedge clk);
        check("nop_no_req", 40'(rise_cnt), 40'd2);

        // Busy: second request while first is outstanding
        shift_dr(40, 40'h08_0000_0001, out);
        check("busy1_capture", out, 40'h44_0000_3208);
        wait_valid("busy1_valid");
        check("busy1_data", dtm_req_data, 40'h08_0000_0001);
        handshake(0);
        shift_dr(40, {6'h03, 32'hdead_beef, 2'b10}, out);
        check("busy2_capture", out, 40'h08_0000_320B);
        repeat (10) @(negedge clk);
        check("busy2_no_req", 40'(rise_cnt), 40'd3);
        check("busy2_valid_low", {39'b0, dtm_req_valid}, 40'h0);
        respond({32'h1234_5678, 2'b00});
        shift_dr(40, 40'h0, out);
        check("sticky_capture", out, 40'h08_48D1_59E3);

        // DTMCS: dmistat=3, clear with dmireset
        shift_ir(5'h10, iro);
        check("ir_dtmcs_capture", {35'b0, iro}, 40'h1);
        shift_dr(32, 40'h0, out);
        check("dtmcs_sticky", out, 40'h0C61);
        shift_dr(32, 40'h0001_0000, out);
        check("dtmcs_sticky2", out, 40'h0C61);
        shift_dr(32, 40'h0, out);
        check("dtmcs_cleared", out, 40'h0061);
        shift_ir(5'h11, iro);
        shift_dr(40, 40'h0, out);
        check("dmi_after_clear", out, 40'h08_48D1_59E0);
        check("total_hs", 40'(hs_cnt), 40'd3);

        // Reset in the middle of a DMI shift
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < 6; i++) tck_cycle(1'b0, 1'b1, b);
        repeat (5) @(negedge clk);
        check("midscan_tdo_high", {39'b0, jtag_TDO}, 40'h1);
        rst_n = 1'b0;
        #1;
        check("midscan_rst_tdo", {39'b0, jtag_TDO}, 40'h0);
        check("midscan_rst_valid", {39'b0, dtm_req_valid}, 40'h0);
        check("midscan_rst_data", dtm_req_data, 40'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 34; i++) tck_cycle(i == 33, 1'b1, b);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        repeat (20) @(negedge clk);
        check("post_rst_no_req", 40'(rise_cnt), 40'd3);
        check("post_rst_valid", {39'b0, dtm_req_valid}, 40'h0);
        tap_reset_to_rti();
        shift_dr(32, {8'h00, pat}, out);
        check("post_rst_dr_scan", out, exp_reset_scan);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
